// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax result path: collector FSM encoding and
// default sizing constants reused by the softmax top.
package softmax_pkg;

   localparam int unsigned NUM_CLASSES_DEF = 10;
   localparam int unsigned DATA_WIDTH_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } collect_state_t;

endpackage

// File: rtl/softmax_result_bank.sv
// NUM_CLASSES x DATA_WIDTH result register file: one write port and a
// registered read port that returns zero for out-of-range addresses.
module softmax_result_bank
   import softmax_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned IDX_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [IDX_WIDTH-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [IDX_WIDTH-1:0]  rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o
);

   localparam logic [IDX_WIDTH:0] NC = NUM_CLASSES[IDX_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_q [NUM_CLASSES];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  rd_in_range;

   assign rd_in_range = ({1'b0, rd_addr_i} < NC);

   // Storage write; reset clears every entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read: captures the pre-write value on a same-cycle write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) begin
            rd_data_q <= rd_in_range ? mem_q[rd_addr_i] : '0;
         end
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/softmax_result_collector.sv
// Collects one softmax result vector into a register bank, tracks the
// arg-max on the fly and hands the bank to the host via done/ack.
// Optional: define SOFTMAX_COLLECT_OVF_EN to add the sticky ovf_err output.
module softmax_result_collector
   import softmax_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned IDX_WIDTH   = 4
) (
   input  logic                  clk1,
   input  logic                  rst,
   input  logic                  valid_data,
   input  logic [DATA_WIDTH-1:0] softmax_out_final,
   input  logic                  end_softmax,
   input  logic                  rd_en,
   input  logic [IDX_WIDTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  ack,
   output logic                  busy,
   output logic                  done,
   output logic [IDX_WIDTH-1:0]  count,
   output logic [IDX_WIDTH-1:0]  max_idx,
   output logic [DATA_WIDTH-1:0] max_val,
`ifdef SOFTMAX_COLLECT_OVF_EN
   output logic                  ovf_err,
`endif
   output logic                  short_err
);

   localparam logic [IDX_WIDTH:0] NC = NUM_CLASSES[IDX_WIDTH:0];

   collect_state_t        state_q;
   logic [IDX_WIDTH-1:0]  count_q;
   logic [IDX_WIDTH-1:0]  max_idx_q;
   logic [DATA_WIDTH-1:0] max_val_q;
   logic                  short_err_q;
   logic                  ovf_q;

   logic                  wr_en;
   logic [IDX_WIDTH-1:0]  wr_addr;
   logic [IDX_WIDTH:0]    cnt_inc;

   // Beats are only stored outside DONE; the first beat of a vector lands at 0.
   assign wr_en   = valid_data && (state_q != ST_DONE);
   assign wr_addr = (state_q == ST_IDLE) ? '0 : count_q;
   // One bit wider so a full 2^IDX_WIDTH vector still reaches NUM_CLASSES.
   assign cnt_inc = {1'b0, count_q} + 1'b1;

   softmax_result_bank #(
      .NUM_CLASSES (NUM_CLASSES),
      .DATA_WIDTH  (DATA_WIDTH),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_bank (
      .clk_i      (clk1),
      .rst_i      (rst),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (softmax_out_final),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid)
   );

   // Collection FSM with beat counter, arg-max tracking and error flags.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         max_idx_q   <= '0;
         max_val_q   <= '0;
         short_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (valid_data) begin
                  count_q     <= {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                  max_val_q   <= softmax_out_final;
                  max_idx_q   <= '0;
                  short_err_q <= 1'b0;
                  state_q     <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (valid_data) begin
                  count_q <= cnt_inc[IDX_WIDTH-1:0];
                  if (softmax_out_final > max_val_q) begin
                     max_val_q <= softmax_out_final;
                     max_idx_q <= count_q;
                  end
                  if (cnt_inc == NC) begin
                     state_q     <= ST_DONE;
                     short_err_q <= 1'b0;
                  end else if (end_softmax) begin
                     state_q     <= ST_DONE;
                     short_err_q <= 1'b1;
                  end
               end else if (end_softmax) begin
                  state_q     <= ST_DONE;
                  short_err_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (ack) begin
                  state_q <= ST_IDLE;
                  ovf_q   <= 1'b0;
               end
               // A dropped beat flags overflow even when it collides with ack.
               if (valid_data) begin
                  ovf_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state_q == ST_COLLECT);
   assign done      = (state_q == ST_DONE);
   assign count     = count_q;
   assign max_idx   = max_idx_q;
   assign max_val   = max_val_q;
   assign short_err = short_err_q;

`ifdef SOFTMAX_COLLECT_OVF_EN
   assign ovf_err = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule
